mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 5 +
 rtl/mem_arb_rdret.sv | 19 +
 rtl/mem_arbiter.sv | 84 ++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared state encoding and hold-counter width for the arbiter
package mem_arbiter_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, OWN_A = 2'd1, OWN_B = 2'd2} state_t;
    localparam int HOLD_W = 8;
endpackage

// File: rtl/mem_arb_rdret.sv
// mem_arb_rdret: one-cycle read-return stage tagging returned bus data to its port
module mem_arb_rdret (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd_a,
    input  logic        rd_b,
    input  logic [15:0] mem_out,
    output logic        a_rvalid,
    output logic        b_rvalid,
    output logic [15:0] a_rdata,
    output logic [15:0] b_rdata
);
    always_ff @(posedge clk) begin
        a_rvalid <= reset ? 1'b0 : rd_a;
        b_rvalid <= reset ? 1'b0 : rd_b;
    end
    assign a_rdata = a_rvalid ? mem_out : '0;
    assign b_rdata = b_rvalid ? mem_out : '0;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port bus arbiter with hold-limit preemption; MEM_ARB_RR_EN enables round-robin tie-break and preemption of both ports
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [15:0] a_addr,
    input  logic [15:0] a_wdata,
    output logic        a_gnt,
    output logic        a_rvalid,
    output logic [15:0] a_rdata,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [15:0] b_addr,
    input  logic [15:0] b_wdata,
    output logic        b_gnt,
    output logic        b_rvalid,
    output logic [15:0] b_rdata,
    output logic [15:0] mem_address,
    output logic [15:0] mem_in,
    output logic        mem_load,
    input  logic [15:0] mem_out
);
    localparam logic [HOLD_W-1:0] MAX = HOLD_W'(MAX_HOLD);
    state_t state, nxt;
    logic [HOLD_W-1:0] hold, hold_inc;
    logic acc_a, acc_b, pre_a, pre_b, pick_b;
    assign acc_a = a_req & a_gnt;
    assign acc_b = b_req & b_gnt;
    assign hold_inc = (hold == MAX) ? MAX : hold + HOLD_W'(1);
`ifdef MEM_ARB_RR_EN
    logic ptr_b;
    assign pre_a = b_req && hold_inc == MAX;
    assign pre_b = a_req && hold_inc == MAX;
    assign pick_b = b_req && (!a_req || ptr_b);
`else
    assign pre_a = 1'b0;
    assign pre_b = a_req && hold_inc == MAX;
    assign pick_b = b_req && !a_req;
`endif
    // Leaving an owner state on a dropped request or on preemption is the same path.
    always_comb begin
        nxt = state == OWN_A ? (a_req && !pre_a ? OWN_A : b_req ? OWN_B : IDLE) :
              state == OWN_B ? (b_req && !pre_b ? OWN_B : a_req ? OWN_A : IDLE) :
              (pick_b ? OWN_B : a_req ? OWN_A : IDLE);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            a_gnt <= 1'b0;
            b_gnt <= 1'b0;
            hold  <= '0;
`ifdef MEM_ARB_RR_EN
            ptr_b <= 1'b0;
`endif
        end else begin
            state <= nxt;
            a_gnt <= nxt == OWN_A;
            b_gnt <= nxt == OWN_B;
            hold  <= (nxt != state) ? '0 : (acc_a | acc_b) ? hold_inc : hold;
`ifdef MEM_ARB_RR_EN
            ptr_b <= nxt == OWN_A ? 1'b1 : nxt == OWN_B ? 1'b0 : ptr_b;
`endif
        end
    end
    assign mem_address = acc_a ? a_addr : acc_b ? b_addr : '0;
    assign mem_in      = acc_a ? a_wdata : acc_b ? b_wdata : '0;
    assign mem_load    = (acc_a & a_we) | (acc_b & b_we);
    mem_arb_rdret u_rdret (
        .clk      (clk),
        .reset    (reset),
        .rd_a     (acc_a & ~a_we),
        .rd_b     (acc_b & ~b_we),
        .mem_out  (mem_out),
        .a_rvalid (a_rvalid),
        .b_rvalid (b_rvalid),
        .a_rdata  (a_rdata),
        .b_rdata  (b_rdata)
    );
endmodule
